// File: rtl/arkhe_meas_pkg.sv
// Shared types and constants for the Arkhe measurement unit: FSM states,
// Q-format constants, LFSR parameters and datapath widths.
package arkhe_meas_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int FRAC_BITS = 15;
  localparam int PROB_W    = 16;
  localparam int ACC_W     = 24;
  localparam int CNT_W     = 16;
  localparam int WSEL_W    = 3;
  localparam int SCNT_W    = 8;

  localparam logic [PROB_W-1:0] ONE       = 16'h8000;
  localparam logic [PROB_W-1:0] MAG_SAT   = 16'hFFFF;
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0]       LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    HOLD
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/arkhe_mag2.sv
// Registered squared-magnitude stage: (re^2 + im^2) >> 15 at full precision,
// saturated to 16 bits, with a valid flag that marks a pending result.
module arkhe_mag2
  import arkhe_meas_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_fire,
  input  logic signed [SAMPLE_W-1:0] psi_re,
  input  logic signed [SAMPLE_W-1:0] psi_im,
  output logic                       mag_valid,
  output logic        [PROB_W-1:0]   mag2
);

  logic signed [2*SAMPLE_W-1:0]         re_sq;
  logic signed [2*SAMPLE_W-1:0]         im_sq;
  logic        [2*SAMPLE_W:0]           sum;
  logic        [2*SAMPLE_W-FRAC_BITS:0] shifted;
  logic        [PROB_W-1:0]             sat;

  // Squares are never negative, so the sum is safely treated as unsigned
  always_comb begin
    re_sq   = (2*SAMPLE_W)'(psi_re) * (2*SAMPLE_W)'(psi_re);
    im_sq   = (2*SAMPLE_W)'(psi_im) * (2*SAMPLE_W)'(psi_im);
    sum     = {1'b0, re_sq} + {1'b0, im_sq};
    shifted = sum[2*SAMPLE_W:FRAC_BITS];
    sat     = (|shifted[$high(shifted):PROB_W]) ? MAG_SAT : shifted[PROB_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_valid <= 1'b0;
      mag2      <= '0;
    end else begin
      mag_valid <= in_fire;
      if (in_fire) mag2 <= sat;
    end
  end

endmodule

// File: rtl/arkhe_measurement_unit.sv
// Averages |psi|^2 over a 2^window_sel sample window and collapses the result
// to a basis state using a free-running LFSR as the random source.
module arkhe_measurement_unit
  import arkhe_meas_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic        [WSEL_W-1:0]   window_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] psi_re,
  input  logic signed [SAMPLE_W-1:0] psi_im,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       outcome,
  output logic        [PROB_W-1:0]   prob_avg,
  output logic        [CNT_W-1:0]    meas_count
);

  state_t              state;
  state_t              state_nxt;
  logic [WSEL_W-1:0]   wsel_q;
  logic [SCNT_W-1:0]   samp_cnt;
  logic [SCNT_W-1:0]   last_idx;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    avg_full;
  logic [PROB_W-1:0]   avg_sat;
  logic [15:0]         lfsr;
  logic [PROB_W-1:0]   mag2;
  logic                mag_valid;
  logic                settle;
  logic                in_fire;
  logic                out_fire;
  logic                last_sample;
  logic                pipe_empty;
  logic                decide_outcome;
  logic                decide_fire;

  arkhe_mag2 u_mag2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_fire   (in_fire),
    .psi_re    (psi_re),
    .psi_im    (psi_im),
    .mag_valid (mag_valid),
    .mag2      (mag2)
  );

  assign in_fire     = (state == ACCUM) && in_valid;
  assign out_fire    = (state == HOLD) && out_ready;
  assign last_idx    = (SCNT_W'(1) << wsel_q) - SCNT_W'(1);
  assign last_sample = in_fire && (samp_cnt == last_idx);
  // The settle flag gives the accumulator one quiet cycle after its final add
  assign pipe_empty  = !mag_valid && !settle;
  assign decide_fire = (state == DECIDE) && pipe_empty;

  always_comb begin
    avg_full       = acc >> wsel_q;
    avg_sat        = (|avg_full[ACC_W-1:PROB_W]) ? MAG_SAT : avg_full[PROB_W-1:0];
    decide_outcome = (avg_sat >= ONE) || (lfsr[14:0] < avg_sat[14:0]);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_sample) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (pipe_empty) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= LFSR_SEED;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_next(lfsr);
    end
  end

  // A fresh start wipes any leftover window state before sampling begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel_q   <= '0;
      samp_cnt <= '0;
      acc      <= '0;
      settle   <= 1'b0;
    end else begin
      settle <= mag_valid;
      if ((state == IDLE) && start) begin
        wsel_q   <= window_sel;
        samp_cnt <= '0;
        acc      <= '0;
      end else begin
        if (in_fire)   samp_cnt <= samp_cnt + SCNT_W'(1);
        if (mag_valid) acc      <= acc + ACC_W'(mag2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prob_avg   <= '0;
      outcome    <= 1'b0;
      meas_count <= '0;
    end else begin
      if (decide_fire) begin
        prob_avg <= avg_sat;
        outcome  <= decide_outcome;
      end
      if (out_fire) meas_count <= meas_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arkhe_measurement_unit.sv
// Self-checking bench for arkhe_measurement_unit: directed corner cases plus
// randomized windows compared against an arithmetic mean-of-|psi|^2 model.
module tb_arkhe_measurement_unit;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [2:0]         window_sel;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] psi_re;
  logic signed [17:0] psi_im;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic               outcome;
  logic [15:0]        prob_avg;
  logic [15:0]        meas_count;

  int                 checks = 0;
  int                 errors = 0;
  logic [15:0]        exp_count;
  logic signed [17:0] sre [128];
  logic signed [17:0] sim [128];

  arkhe_measurement_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .window_sel (window_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psi_re     (psi_re),
    .psi_im     (psi_im),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outcome    (outcome),
    .prob_avg   (prob_avg),
    .meas_count (meas_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mean of the saturated per-sample |psi|^2 in Q1.15 over n samples
  function automatic logic [15:0] modelAvg(input int n);
    longint sum = 0;
    longint m;
    for (int i = 0; i < n; i++) begin
      m = (longint'(sre[i]) * longint'(sre[i]) + longint'(sim[i]) * longint'(sim[i])) / 32768;
      if (m > 65535) m = 65535;
      sum += m;
    end
    sum = sum / n;
    if (sum > 65535) sum = 65535;
    return 16'(sum);
  endfunction

  task automatic applyStimulus(input int ws, input bit gaps, output int latency);
    int n;
    int guard;
    n = 1 << ws;
    window_sel = 3'(ws);
    start = 1'b1;
    tick();
    start = 1'b0;
    window_sel = 3'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        psi_re = 18'($urandom);
        tick();
      end
      in_valid = 1'b1;
      psi_re = sre[i];
      psi_im = sim[i];
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      checkOutput("in_ready_accum", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    psi_re = '0;
    psi_im = '0;
    checkOutput("in_ready_after_last", in_ready, 0);
    latency = 0;
    while (!out_valid && latency < 20) begin
      tick();
      latency++;
    end
  endtask

  task automatic runMeasurement(input string tag, input int ws, input bit gaps,
                                input int stall, output logic oc);
    int lat;
    logic [15:0] ea;
    ea = modelAvg(1 << ws);
    applyStimulus(ws, gaps, lat);
    checkOutput({tag, "_latency"}, lat, 3);
    checkOutput({tag, "_busy_hold"}, busy, 1);
    checkOutput({tag, "_prob_avg"}, prob_avg, ea);
    if (ea >= 16'h8000) checkOutput({tag, "_outcome"}, outcome, 1);
    else if (ea == 16'h0000) checkOutput({tag, "_outcome"}, outcome, 0);
    checkOutput({tag, "_count_hold"}, meas_count, exp_count);
    oc = outcome;
    for (int c = 0; c < stall; c++) begin
      out_ready = 1'b0;
      start = (c == 3);
      in_valid = 1'b1;
      psi_re = 18'($urandom);
      psi_im = 18'($urandom);
      tick();
      checkOutput({tag, "_stall_valid"}, out_valid, 1);
      checkOutput({tag, "_stall_in_ready"}, in_ready, 0);
      checkOutput({tag, "_stall_prob"}, prob_avg, ea);
      checkOutput({tag, "_stall_outcome"}, outcome, oc);
      checkOutput({tag, "_stall_count"}, meas_count, exp_count);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count++;
    checkOutput({tag, "_valid_drop"}, out_valid, 0);
    checkOutput({tag, "_count"}, meas_count, exp_count);
    checkOutput({tag, "_busy_idle"}, busy, 0);
    checkOutput({tag, "_prob_retain"}, prob_avg, ea);
    checkOutput({tag, "_outcome_retain"}, outcome, oc);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_prob_avg", prob_avg, 0);
    checkOutput("reset_outcome", outcome, 0);
    checkOutput("reset_meas_count", meas_count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = '0;
    tick();
  endtask

  initial begin
    logic oc;
    logic signed [17:0] r;
    int ws;
    int ones;

    start = 1'b0;
    window_sel = '0;
    in_valid = 1'b0;
    psi_re = '0;
    psi_im = '0;
    out_ready = 1'b0;
    exp_count = '0;
    doReset();

    // Unit amplitude, single sample
    sre[0] = 18'sh08000; sim[0] = 18'sh00000;
    runMeasurement("req031", 0, 1'b0, 0, oc);

    // Saturation of a single oversize sample
    sre[0] = 18'sh1FFFF; sim[0] = 18'sh1FFFF;
    runMeasurement("req033", 0, 1'b0, 0, oc);
    checkOutput("req033_sat", prob_avg, 16'hFFFF);

    // Back-to-back windows after a clean reset
    doReset();
    for (int i = 0; i < 4; i++) begin sre[i] = -18'sh08000; sim[i] = '0; end
    runMeasurement("req032a", 2, 1'b0, 0, oc);
    for (int i = 0; i < 4; i++) begin sre[i] = '0; sim[i] = '0; end
    runMeasurement("req032b", 2, 1'b0, 0, oc);
    checkOutput("req032_count", meas_count, 2);

    // Stalled result with start and in_valid poked during HOLD
    for (int i = 0; i < 2; i++) begin sre[i] = 18'sh06000; sim[i] = 18'sh03000; end
    runMeasurement("req034", 1, 1'b0, 10, oc);

    // Randomized windows against the reference model
    for (int k = 0; k < 12; k++) begin
      ws = $urandom_range(0, 5);
      for (int i = 0; i < (1 << ws); i++) begin
        r = 18'($urandom);
        sre[i] = r >>> $urandom_range(0, 6);
        r = 18'($urandom);
        sim[i] = r >>> $urandom_range(0, 6);
      end
      runMeasurement("rand", ws, 1'b1, 0, oc);
    end

    // Asynchronous reset in the middle of a window
    window_sel = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      psi_re = 18'sh08000;
      psi_im = '0;
      tick();
    end
    #2;
    doReset();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin sre[i] = 18'sh08000; sim[i] = '0; end
    runMeasurement("req035", 3, 1'b0, 0, oc);
    checkOutput("req035_prob", prob_avg, 16'h8000);

    // Collapse statistics near one half
    ones = 0;
    sre[0] = 18'sh05A82; sim[0] = '0;
    for (int k = 0; k < 1024; k++) begin
      runMeasurement("req036", 0, 1'b0, 0, oc);
      if (oc === 1'b1) ones++;
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end
    $display("[TB] req036 outcome=1 count %0d of 1024", ones);
    checkOutput("req036_fraction", (ones >= 461 && ones <= 563), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
